// File: rtl/io_seq_pkg.sv
// Shared definitions for the IO bank power sequencer.
//   SETTLE_W_DEF : default width of the settle counter and settle inputs
//   seq_state_e  : sequencer FSM states with fixed encodings
package io_seq_pkg;

  localparam int unsigned SETTLE_W_DEF = 16;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WB_ON    = 4'd1,
    WB_WAIT  = 4'd2,
    RET_OFF  = 4'd3,
    RET_WAIT = 4'd4,
    OE_ON    = 4'd5,
    OE_OFF   = 4'd6,
    RET_ON   = 4'd7,
    WB_OFF   = 4'd8
  } seq_state_e;

endpackage

// File: rtl/io_rr_arb.sv
// Round-robin arbiter: picks the first requesting bank at or above ptr,
// wrapping to the lowest requesting bank when none is found there.
//   req : request vector, one bit per bank
//   ptr : index of the highest-priority bank for this decision
//   gnt : one-hot grant (all zero when req is zero)
module io_rr_arb
  import io_seq_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned IDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic [NUM_BANKS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_BANKS-1:0] gnt
);

  logic [NUM_BANKS-1:0] lo_mask;
  logic [NUM_BANKS-1:0] hi_req;

  // x & (~x + 1) isolates the lowest set bit of x.
  always_comb begin
    lo_mask = (NUM_BANKS'(1) << ptr) - NUM_BANKS'(1);
    hi_req  = req & ~lo_mask;
    if (hi_req != '0) gnt = hi_req & (~hi_req + NUM_BANKS'(1));
    else              gnt = req & (~req + NUM_BANKS'(1));
  end

endmodule

// File: rtl/io_bank_pwr_seq.sv
// IO bank power sequencer: brings pad banks up (well bias on, settle,
// retention release, settle, output enable) and down (output disable,
// retention hold, well bias off), one bank at a time, round-robin.
//   clk, rst               : clock, asynchronous active-high reset
//   up_req, dn_req         : per-bank level requests, held until ack
//   ack                    : one-cycle completion pulse per bank
//   wb_settle, ret_settle  : settle cycle counts, sampled at counter load
//   wb_en, ret, oe_allow   : per-bank pad controls (registered)
//   bank_up                : per-bank fully-powered status
//   busy                   : sequencer active or work pending
module io_bank_pwr_seq
  import io_seq_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned SETTLE_W  = SETTLE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] up_req,
  input  logic [NUM_BANKS-1:0] dn_req,
  output logic [NUM_BANKS-1:0] ack,
  input  logic [SETTLE_W-1:0]  wb_settle,
  input  logic [SETTLE_W-1:0]  ret_settle,
  output logic [NUM_BANKS-1:0] wb_en,
  output logic [NUM_BANKS-1:0] ret,
  output logic [NUM_BANKS-1:0] oe_allow,
  output logic [NUM_BANKS-1:0] bank_up,
  output logic                 busy
);

  localparam int unsigned IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  seq_state_e           state_q, state_nxt;
  logic [SETTLE_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_BANKS-1:0] cur_oh, cur_d, sel_oh;
  logic [NUM_BANKS-1:0] wb_en_d, ret_d, oe_d, up_d, ack_d;
  logic                 busy_d;
  logic [NUM_BANKS-1:0] up_pend, dn_pend, pend, sat, gnt;

  // up_req wins when both requests are raised for a bank.
  assign up_pend = up_req & ~bank_up;
  assign dn_pend = dn_req & ~up_req & bank_up;
  assign pend    = up_pend | dn_pend;
  assign sat     = (up_req & bank_up) | (dn_req & ~up_req & ~bank_up);

  io_rr_arb #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req (pend),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      cur_oh   <= '0;
      wb_en    <= '0;
      ret      <= '1;
      oe_allow <= '0;
      bank_up  <= '0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      cur_oh   <= cur_d;
      wb_en    <= wb_en_d;
      ret      <= ret_d;
      oe_allow <= oe_d;
      bank_up  <= up_d;
      ack      <= ack_d;
      busy     <= busy_d;
    end
  end

  // Wait states leave when the counter is about to reach zero, so a
  // settle value of N spends exactly N cycles waiting.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:     if (pend != '0) state_nxt = ((gnt & up_pend) != '0) ? WB_ON : OE_OFF;
      WB_ON:    state_nxt = (cnt_q == '0) ? RET_OFF : WB_WAIT;
      WB_WAIT:  if (cnt_q == SETTLE_W'(1)) state_nxt = RET_OFF;
      RET_OFF:  state_nxt = (cnt_q == '0) ? OE_ON : RET_WAIT;
      RET_WAIT: if (cnt_q == SETTLE_W'(1)) state_nxt = OE_ON;
      OE_ON:    state_nxt = IDLE;
      OE_OFF:   state_nxt = RET_ON;
      RET_ON:   state_nxt = WB_OFF;
      WB_OFF:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered: each state's actions are computed on the edge
  // that enters it, so the pins change together with the state register.
  always_comb begin
    sel_oh  = (state_q == IDLE) ? gnt : cur_oh;
    cur_d   = sel_oh;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wb_en_d = wb_en;
    ret_d   = ret;
    oe_d    = oe_allow;
    up_d    = bank_up;
    ack_d   = '0;
    // Pending work keeps busy high across the IDLE cycle between banks.
    busy_d  = (state_nxt != IDLE) || (pend != '0);

    if (state_q == IDLE) begin
      ack_d = sat;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (gnt == (NUM_BANKS'(1) << i))
          ptr_d = (i == NUM_BANKS - 1) ? '0 : IDX_W'(i + 1);
      end
    end

    if (state_q inside {WB_WAIT, RET_WAIT}) cnt_d = cnt_q - SETTLE_W'(1);

    if (state_nxt != state_q) begin
      case (state_nxt)
        WB_ON: begin
          wb_en_d = wb_en | sel_oh;
          cnt_d   = wb_settle;
        end
        RET_OFF: begin
          ret_d = ret & ~sel_oh;
          cnt_d = ret_settle;
        end
        OE_ON: begin
          oe_d  = oe_allow | sel_oh;
          up_d  = bank_up | sel_oh;
          ack_d = ack_d | sel_oh;
        end
        OE_OFF: begin
          oe_d = oe_allow & ~sel_oh;
          up_d = bank_up & ~sel_oh;
        end
        RET_ON: ret_d = ret | sel_oh;
        WB_OFF: begin
          wb_en_d = wb_en & ~sel_oh;
          ack_d   = ack_d | sel_oh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bank_pwr_seq.sv
module tb_io_bank_pwr_seq;

  localparam int NB = 4;
  localparam int SW = 16;

  logic          clk;
  logic          rst        = 1'b1;
  logic [NB-1:0] up_req     = '0;
  logic [NB-1:0] dn_req     = '0;
  logic [SW-1:0] wb_settle  = '0;
  logic [SW-1:0] ret_settle = '0;
  logic [NB-1:0] ack, wb_en, ret, oe_allow, bank_up;
  logic          busy;

  int checks = 0;
  int errors = 0;

  io_bank_pwr_seq #(.NUM_BANKS(NB), .SETTLE_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_req     (up_req),
    .dn_req     (dn_req),
    .ack        (ack),
    .wb_settle  (wb_settle),
    .ret_settle (ret_settle),
    .wb_en      (wb_en),
    .ret        (ret),
    .oe_allow   (oe_allow),
    .bank_up    (bank_up),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] e_wb, input logic [NB-1:0] e_ret,
                         input logic [NB-1:0] e_oe, input logic [NB-1:0] e_up,
                         input logic [NB-1:0] e_ack, input logic e_busy);
    chk({tag, ".wb_en"}, wb_en, e_wb);
    chk({tag, ".ret"}, ret, e_ret);
    chk({tag, ".oe_allow"}, oe_allow, e_oe);
    chk({tag, ".bank_up"}, bank_up, e_up);
    chk({tag, ".ack"}, ack, e_ack);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a served bank runs a timeline measured in cycles
  // from its grant; step times follow from the latched settle values.
  logic [NB-1:0] m_wb, m_ret, m_oe, m_up, m_ack;
  logic          m_busy;
  bit            act, act_up;
  logic [NB-1:0] act_m;
  int            act_t, w_lat, r_lat, m_ptr;

  task automatic model_reset();
    m_wb = '0; m_ret = '1; m_oe = '0; m_up = '0; m_ack = '0; m_busy = 1'b0;
    act = 1'b0; act_up = 1'b0; act_m = '0; act_t = 0; w_lat = 0; r_lat = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    logic [NB-1:0] u, d, pv, sv, bm;
    int b, j;
    u = up_req;
    d = dn_req;
    pv = (u & ~m_up) | (d & ~u & m_up);
    sv = (u & m_up) | (d & ~u & ~m_up);
    m_ack = '0;
    if (!act) begin
      m_ack = sv;
      b = -1;
      for (int k = 0; k < NB; k++) begin
        j = (m_ptr + k) % NB;
        bm = NB'(1) << j;
        if (b < 0 && (pv & bm) != '0) b = j;
      end
      if (b >= 0) begin
        act = 1'b1;
        act_m = NB'(1) << b;
        act_up = (u & act_m) != '0;
        act_t = 0;
        m_ptr = (b + 1) % NB;
        if (act_up) begin
          w_lat = int'(wb_settle);
          m_wb = m_wb | act_m;
        end else begin
          m_oe = m_oe & ~act_m;
          m_up = m_up & ~act_m;
        end
      end
    end else begin
      act_t++;
      if (act_up) begin
        if (act_t == 1 + w_lat) begin
          m_ret = m_ret & ~act_m;
          r_lat = int'(ret_settle);
        end else if (act_t == 2 + w_lat + r_lat) begin
          m_oe = m_oe | act_m;
          m_up = m_up | act_m;
          m_ack = act_m;
        end else if (act_t == 3 + w_lat + r_lat) begin
          act = 1'b0;
        end
      end else begin
        if (act_t == 1) m_ret = m_ret | act_m;
        else if (act_t == 2) begin
          m_wb = m_wb & ~act_m;
          m_ack = act_m;
        end else if (act_t == 3) act = 1'b0;
      end
    end
    m_busy = act || (pv != '0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare process: DUT against model each cycle, plus pad invariants.
  initial begin
    forever begin
      @(negedge clk);
      chk_all("model", m_wb, m_ret, m_oe, m_up, m_ack, m_busy);
      checks++;
      assert (((oe_allow & ret) == '0) && ((~ret & ~wb_en) == '0))
      else begin
        errors++;
        $display("FAIL invariant: oe_allow=%b ret=%b wb_en=%b at %0t", oe_allow, ret, wb_en, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Requesters drop their request once they see its ack.
  task automatic step();
    @(posedge clk);
    #1;
    up_req = up_req & ~ack;
    dn_req = dn_req & ~ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_req = '0;
    dn_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] e_ack, bm;
    int r;

    do_reset();
    chk_all("reset", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Bank 2 up, wb_settle=3, ret_settle=2; settles changed after load.
    wb_settle = 16'd3;
    ret_settle = 16'd2;
    up_req = 4'b0100;
    step();
    chk_all("s1k1", 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    chk_all("s1k2", 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wb_settle = 16'd9;
    step();
    chk_all("s1k3", 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    chk_all("s1k4", 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    chk_all("s1k5", 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    ret_settle = 16'd7;
    step();
    chk_all("s1k6", 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    chk_all("s1k7", 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    chk_all("s1k8", 4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    step();
    chk_all("s1k9", 4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0000, 1'b0);

    // Already-satisfied requests: ack next cycle, nothing else moves.
    up_req = 4'b0100;
    step();
    chk_all("s4up", 4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0100, 1'b0);
    dn_req = 4'b0001;
    step();
    chk_all("s4dn", 4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0001, 1'b0);
    step();
    chk_all("s4end", 4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0000, 1'b0);

    // Three simultaneous up requests, zero settle: served 0, 1, 3.
    do_reset();
    wb_settle = '0;
    ret_settle = '0;
    up_req = 4'b1011;
    for (int k = 1; k <= 12; k++) begin
      step();
      e_ack = (k == 3) ? 4'b0001 : (k == 7) ? 4'b0010 : (k == 11) ? 4'b1000 : 4'b0000;
      chk($sformatf("s2k%0d.ack", k), ack, e_ack);
      chk($sformatf("s2k%0d.busy", k), {3'b000, busy}, {3'b000, (k <= 11) ? 1'b1 : 1'b0});
    end
    chk_all("s2end", 4'b1011, 4'b0100, 4'b1011, 4'b1011, 4'b0000, 1'b0);

    // Bank 1 down: oe off, retention on, well bias off on consecutive cycles.
    dn_req = 4'b0010;
    step();
    chk_all("s3k1", 4'b1011, 4'b0100, 4'b1001, 4'b1001, 4'b0000, 1'b1);
    step();
    chk_all("s3k2", 4'b1011, 4'b0110, 4'b1001, 4'b1001, 4'b0000, 1'b1);
    step();
    chk_all("s3k3", 4'b1001, 4'b0110, 4'b1001, 4'b1001, 4'b0010, 1'b1);
    step();
    chk_all("s3k4", 4'b1001, 4'b0110, 4'b1001, 4'b1001, 4'b0000, 1'b0);

    // Reset during bank 3 well-bias settle wait.
    do_reset();
    wb_settle = 16'd20;
    ret_settle = 16'd1;
    up_req = 4'b1000;
    step();
    chk_all("s5on", 4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    repeat (4) step();
    chk_all("s5wait", 4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    #2;
    rst = 1'b1;
    up_req = '0;
    #1;
    chk_all("s5rst", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_all("s5after", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Random request traffic with withdrawals and changing settle values.
    for (int c = 0; c < 1500; c++) begin
      wb_settle = SW'($urandom_range(0, 3));
      ret_settle = SW'($urandom_range(0, 3));
      for (int i = 0; i < NB; i++) begin
        bm = NB'(1) << i;
        if (((up_req | dn_req) & bm) == '0) begin
          if ($urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) up_req = up_req | bm;
            else if (r < 9) dn_req = dn_req | bm;
            else begin
              up_req = up_req | bm;
              dn_req = dn_req | bm;
            end
          end
        end else if ($urandom_range(0, 63) == 0) begin
          up_req = up_req & ~bm;
          dn_req = dn_req & ~bm;
        end
      end
      step();
    end
    up_req = '0;
    dn_req = '0;
    repeat (30) step();
    chk("drain.busy", {3'b000, busy}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bank_pwr_seq.md
IO_BANK_PWR_SEQ -- requirements
Module: io_bank_pwr_seq

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of IO pad banks sequenced (1..8).
REQ-002 SHALL have parameter SETTLE_W, default 16, width of settle-delay counter and config fields.
REQ-003 SHALL have port clk  input  1  single block clock; all state in this domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port up_req  input  NUM_BANKS  per-bank power-up request, level, held until ack.
REQ-006 SHALL have port dn_req  input  NUM_BANKS  per-bank power-down request, level, held until ack.
REQ-007 SHALL have port ack  output  NUM_BANKS  one-cycle completion pulse per bank.
REQ-008 SHALL have port wb_settle  input  SETTLE_W  cycles to wait after well-filter bias enable.
REQ-009 SHALL have port ret_settle  input  SETTLE_W  cycles to wait after retention release.
REQ-010 SHALL have port wb_en  output  NUM_BANKS  well-filter/well-bias enable per bank.
REQ-011 SHALL have port ret  output  NUM_BANKS  pad retention hold per bank, active-high.
REQ-012 SHALL have port oe_allow  output  NUM_BANKS  functional output-enable gate per bank.
REQ-013 SHALL have port bank_up  output  NUM_BANKS  bank fully powered status.
REQ-014 SHALL have port busy  output  1  sequencer not in IDLE.

Function
REQ-015 SHALL serve one bank at a time through one shared FSM and one shared settle counter.
REQ-016 SHALL select among pending banks round-robin, starting from the bank after the last served; bank 0 first after reset.
REQ-017 Pending for bank b SHALL be (up_req[b] and not bank_up[b]) or (dn_req[b] and bank_up[b]); up_req and dn_req both high SHALL be treated as up_req.
REQ-018 A request already satisfied (up_req with bank_up=1, dn_req with bank_up=0) SHALL receive ack one cycle after seen in IDLE, no output change, no arbitration slot consumed.
REQ-019 FSM states: IDLE, WB_ON, WB_WAIT, RET_OFF, RET_WAIT, OE_ON, OE_OFF, RET_ON, WB_OFF.
REQ-020 Up sequence: IDLE->WB_ON (wb_en=1, counter loaded wb_settle)->WB_WAIT until counter 0->RET_OFF (ret=0, counter loaded ret_settle)->RET_WAIT until 0->OE_ON (oe_allow=1, bank_up=1, ack pulse)->IDLE.
REQ-021 Down sequence: IDLE->OE_OFF (oe_allow=0, bank_up=0)->RET_ON (ret=1)->WB_OFF (wb_en=0, ack pulse)->IDLE; one cycle per state.
REQ-022 Settle value 0 SHALL skip the wait state (zero extra cycles); value N SHALL give exactly N wait cycles.
REQ-023 Settle inputs SHALL be sampled only at counter load; later changes SHALL not affect a running wait.
REQ-024 Withdrawal of a request mid-sequence SHALL NOT abort; sequence completes and ack still pulses.
REQ-025 Invariants, every cycle: oe_allow[b] implies not ret[b]; not ret[b] implies wb_en[b].
REQ-026 busy SHALL be 0 only in IDLE.

Reset
REQ-027 On rst: wb_en=0, ret=all ones, oe_allow=0, bank_up=0, ack=0, busy=0, FSM=IDLE, counter=0, round-robin pointer=bank 0.
REQ-028 Reset asserted mid-sequence SHALL force REQ-027 values asynchronously; no ack for the interrupted request.
REQ-029 After rst deassertion, first arbitration SHALL occur on the first clk edge.

Structure
REQ-030 FSM state enum and state encoding SHALL live in shared package io_seq_pkg, with SETTLE_W default constant.
REQ-031 Round-robin arbiter SHALL be one sub-module, io_rr_arb (request vector, pointer, one-hot grant).
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-033 Bank 2 up_req, wb_settle=3, ret_settle=2 -> wb_en[2] rises, ret[2] falls 4 cycles later, oe_allow[2]/bank_up[2]/ack[2] 3 cycles after that.
REQ-034 up_req=4'b1011 simultaneously, settles 0 -> banks served in order 0,1,3; one ack each; busy high throughout.
REQ-035 Bank 1 up, then dn_req[1] -> oe_allow[1]=0, ret[1]=1, wb_en[1]=0 on consecutive cycles, ack on WB_OFF cycle.
REQ-036 up_req[0] with bank_up[0]=1 -> ack[0] next cycle, no output change, busy stays 0.
REQ-037 rst during WB_WAIT of bank 3 -> all outputs at reset values immediately; no ack[3].
REQ-038 Assertion checker on REQ-025 invariants active in all scenarios, including random request traffic.
